// File: rtl/fetch_unit.sv
// Instruction fetch initiator: walks the PC, issues single-cycle reads to the
// instruction memory and presents each captured word to the decoder over valid/ready.
module fetch_unit #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 14,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OPC = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_add,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_add_q, mem_add_d;
    logic              mem_en_q, mem_en_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              busy_q, busy_d;
    logic              accept;
    logic              is_halt;

    assign accept  = instr_valid_q && instr_ready;
    assign is_halt = (instr_out_q[DATA_W-1 -: 4] == HALT_OPC);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                instr_out_d   = mem_rdata;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                state_d       = HOLD;
            end
            HOLD: begin
                if (accept) begin
                    instr_valid_d = 1'b0;
                    pc_d          = pc_q + ADDR_W'(1);
                    state_d       = is_halt ? IDLE : REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A redirect while fetching wins over capture, handshake and HALT alike.
        if (redirect && (state_q != IDLE)) begin
            pc_d          = redirect_pc;
            instr_out_d   = instr_out_q;
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            state_d       = REQ;
        end

        // The read strobe is registered so it lines up exactly with the REQ cycle.
        mem_en_d  = (state_d == REQ);
        mem_add_d = mem_en_d ? pc_d : mem_add_q;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            mem_add_q     <= '0;
            mem_en_q      <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_add_q     <= mem_add_d;
            mem_en_q      <= mem_en_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_add     = mem_add_q;
    assign mem_en      = mem_en_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;

endmodule
